bicubic_tap_mac: RTL and testbench

- Parametrised N-tap multiply-accumulate for the bicubic interpolation datapath.
- Computes one filtered pixel per accepted beat: out = clamp(round(sum(pix[i]*coef[i]) / 2^FRAC_W)).
- Replaces the fixed-width single-path add/subtract/slice stage with a general signed MAC that adds rounding, saturation and valid/ready flow control.
- Sits between the coefficient generator and the line-buffer/output formatter; one instance per colour channel.

---
 rtl/bicubic_pkg.sv | 38 +++
 rtl/mac_add_tree_stage.sv | 44 ++++
 rtl/bicubic_tap_mac.sv | 151 +++++++++++++++
 tb/tb_bicubic_tap_mac.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bicubic_pkg.sv
// rtl/bicubic_pkg.sv - shared widths, constants and helpers for the bicubic MAC
package bicubic_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_COEF_W = 10;
    localparam int DEF_FRAC_W = 8;

    // Catmull-Rom weights at t = 0.5 in Q(FRAC_W=8)
    localparam int CR_C0 = -16;
    localparam int CR_C1 = 144;
    localparam int CR_C2 = 144;
    localparam int CR_C3 = -16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

    function automatic int round_half(input int frac_w);
        return (frac_w > 0) ? (1 << (frac_w - 1)) : 0;
    endfunction

    // Bit offset of adder-tree level lvl inside the flat tree bus; level k holds
    // taps>>k lanes of prod_w+k bits each.
    function automatic int tree_off(input int taps, input int prod_w, input int lvl);
        int off;
        off = 0;
        for (int k = 0; k < lvl; k++) begin
            off = off + (taps >> k) * (prod_w + k);
        end
        return off;
    endfunction

endpackage

// File: rtl/mac_add_tree_stage.sv
// rtl/mac_add_tree_stage.sv - one registered pairwise signed add level with valid/enable
module mac_add_tree_stage #(
    parameter int N_OUT = 2,
    parameter int IN_W  = 19
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       in_valid,
    input  logic [2*N_OUT*IN_W-1:0]    data_in,
    output logic                       out_valid,
    output logic [N_OUT*(IN_W+1)-1:0]  data_out
);

    logic [N_OUT*(IN_W+1)-1:0] sum_d;

    for (genvar j = 0; j < N_OUT; j++) begin : g_pair
        logic [IN_W-1:0] a_raw;
        logic [IN_W-1:0] b_raw;
        logic [IN_W:0]   a_ext;
        logic [IN_W:0]   b_ext;
        assign a_raw = data_in[(2*j)*IN_W +: IN_W];
        assign b_raw = data_in[(2*j+1)*IN_W +: IN_W];
        assign a_ext = {a_raw[IN_W-1], a_raw};
        assign b_ext = {b_raw[IN_W-1], b_raw};
        // One guard bit per level keeps the pairwise sum exact.
        assign sum_d[j*(IN_W+1) +: IN_W+1] = a_ext + b_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (en) begin
            out_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            data_out <= sum_d;
        end
    end

endmodule

// File: rtl/bicubic_tap_mac.sv
// rtl/bicubic_tap_mac.sv - pipelined N-tap signed MAC with rounding, clamp and flow control
// Optional saturation counter enabled by defining BICUBIC_MAC_SAT_CNT_EN.
module bicubic_tap_mac
    import bicubic_pkg::*;
#(
    parameter int TAPS   = 4,
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int OUT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TAPS*DATA_W-1:0]   pix_in,
    input  logic [TAPS*COEF_W-1:0]   coef_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_pix,
    output logic                     out_sat,
    output logic [15:0]              sat_cnt,
    input  logic                     sat_clr
);

    localparam int LOG_T  = clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam int SUM_W  = PROD_W + LOG_T;
    localparam int BUS_W  = tree_off(TAPS, PROD_W, LOG_T + 1);

    localparam logic signed [SUM_W:0] RND     = (SUM_W+1)'(round_half(FRAC_W));
    localparam logic signed [SUM_W:0] PIX_MAX = (SUM_W+1)'((1 << OUT_W) - 1);

    logic advance;
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    logic [TAPS*PROD_W-1:0] prod_d;
    logic [TAPS*PROD_W-1:0] prod_q;
    logic                   prod_vld;

    for (genvar i = 0; i < TAPS; i++) begin : g_mul
        logic [DATA_W-1:0]        px_raw;
        logic [COEF_W-1:0]        cf_raw;
        logic signed [PROD_W-1:0] px;
        logic signed [PROD_W-1:0] cf;
        logic signed [PROD_W-1:0] p;
        assign px_raw = pix_in[i*DATA_W +: DATA_W];
        assign cf_raw = coef_in[i*COEF_W +: COEF_W];
        assign px = {{(COEF_W+1){1'b0}}, px_raw};
        assign cf = {{(DATA_W+1){cf_raw[COEF_W-1]}}, cf_raw};
        // Truncation to PROD_W is exact: the true product always fits.
        assign p  = px * cf;
        assign prod_d[i*PROD_W +: PROD_W] = p;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_vld <= 1'b0;
        end else if (advance) begin
            prod_vld <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            prod_q <= prod_d;
        end
    end

    // Flat bus holding every tree level back to back, level 0 = registered products.
    logic [BUS_W-1:0] tree_bus;
    logic [LOG_T:0]   tree_vld;

    assign tree_bus[TAPS*PROD_W-1:0] = prod_q;
    assign tree_vld[0]               = prod_vld;

    for (genvar l = 0; l < LOG_T; l++) begin : g_lvl
        localparam int N_IN    = TAPS >> l;
        localparam int N_OUT   = TAPS >> (l + 1);
        localparam int IN_W    = PROD_W + l;
        localparam int OFF_IN  = tree_off(TAPS, PROD_W, l);
        localparam int OFF_OUT = tree_off(TAPS, PROD_W, l + 1);

        mac_add_tree_stage #(
            .N_OUT (N_OUT),
            .IN_W  (IN_W)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (advance),
            .in_valid  (tree_vld[l]),
            .data_in   (tree_bus[OFF_IN +: N_IN*IN_W]),
            .out_valid (tree_vld[l+1]),
            .data_out  (tree_bus[OFF_OUT +: N_OUT*(IN_W+1)])
        );
    end

    logic [SUM_W-1:0]       sum_tot;
    logic signed [SUM_W:0]  sum_ext;
    logic signed [SUM_W:0]  rounded;
    logic signed [SUM_W:0]  shifted;
    logic [OUT_W-1:0]       pix_d;
    logic                   sat_d;

    assign sum_tot = tree_bus[BUS_W-1 -: SUM_W];
    assign sum_ext = {sum_tot[SUM_W-1], sum_tot};
    assign rounded = sum_ext + RND;
    assign shifted = rounded >>> FRAC_W;

    always_comb begin
        pix_d = shifted[OUT_W-1:0];
        sat_d = 1'b0;
        if (shifted[SUM_W]) begin
            pix_d = '0;
            sat_d = 1'b1;
        end else if (shifted > PIX_MAX) begin
            pix_d = '1;
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_sat   <= 1'b0;
        end else if (advance) begin
            out_valid <= tree_vld[LOG_T];
            out_pix   <= pix_d;
            out_sat   <= sat_d;
        end
    end

`ifdef BICUBIC_MAC_SAT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if (out_valid && out_ready && out_sat && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`else
    logic sat_clr_unused;
    assign sat_clr_unused = sat_clr;
    assign sat_cnt        = '0;
`endif

endmodule

// File: tb/tb_bicubic_tap_mac.sv
// tb/tb_bicubic_tap_mac.sv - directed self-checking bench for bicubic_tap_mac
`timescale 1ns/1ps
module tb_bicubic_tap_mac;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pix_in;
    logic [39:0] coef_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pix;
    logic        out_sat;
    logic [15:0] sat_cnt;
    logic        sat_clr;

    int tests = 0;
    int fails = 0;

`ifdef BICUBIC_MAC_SAT_CNT_EN
    localparam int SC = 1;
`else
    localparam int SC = 0;
`endif

    bicubic_tap_mac dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pix_in    (pix_in),
        .coef_in   (coef_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .out_sat   (out_sat),
        .sat_cnt   (sat_cnt),
        .sat_clr   (sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] pk8(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [39:0] pk10(input int a, input int b, input int c, input int d);
        return {10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    task automatic fail_rpt(input string tag, input int obs, input int exp_v);
        fails++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    endtask

    task automatic run_one(input logic [31:0] p, input logic [39:0] c,
                           input int ep, input int es, input string tag);
        int lat;
        @(posedge clk); #1;
        pix_in   = p;
        coef_in  = c;
        in_valid = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) fail_rpt({tag, "_rdy"}, int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (lat != 4) fail_rpt({tag, "_lat"}, lat, 4);
        tests++;
        if (int'(out_pix) != ep) fail_rpt({tag, "_pix"}, int'(out_pix), ep);
        tests++;
        if (int'(out_sat) != es) fail_rpt({tag, "_sat"}, int'(out_sat), es);
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) fail_rpt({tag, "_drain"}, int'(out_valid), 0);
    endtask

    int   got[$];
    int   sent;
    logic acc;
    logic stall_seen;
    logic [7:0] stall_pix;
    int   wait_cnt;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        pix_in    = '0;
        coef_in   = '0;
        out_ready = 1'b1;
        sat_clr   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) fail_rpt("rst_valid", int'(out_valid), 0);
        tests++;
        if (out_pix !== 8'd0) fail_rpt("rst_pix", int'(out_pix), 0);
        tests++;
        if (out_sat !== 1'b0) fail_rpt("rst_sat", int'(out_sat), 0);
        tests++;
        if (sat_cnt !== 16'd0) fail_rpt("rst_cnt", int'(sat_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) fail_rpt("rel_rdy", int'(in_ready), 1);

        run_one(pk8(0, 77, 0, 0), pk10(0, 256, 0, 0), 77, 0, "identity");
        run_one(pk8(100, 200, 200, 100), pk10(-16, 144, 144, -16), 213, 0, "half");
        run_one(pk8(0, 255, 255, 0), pk10(-16, 144, 144, -16), 255, 1, "over");
        tests++;
        if (int'(sat_cnt) != SC * 1) fail_rpt("cnt_over", int'(sat_cnt), SC * 1);
        run_one(pk8(255, 0, 0, 255), pk10(-16, 144, 144, -16), 0, 1, "under");
        tests++;
        if (int'(sat_cnt) != SC * 2) fail_rpt("cnt_under", int'(sat_cnt), SC * 2);
        run_one(pk8(1, 0, 0, 0), pk10(128, 0, 0, 0), 1, 0, "tie_pos");
        run_one(pk8(1, 0, 0, 0), pk10(-128, 0, 0, 0), 0, 0, "tie_neg");
        run_one(pk8(1, 0, 0, 0), pk10(-129, 0, 0, 0), 0, 1, "neg_one");
        run_one(pk8(255, 0, 0, 0), pk10(256, 0, 0, 0), 255, 0, "max_exact");
        tests++;
        if (int'(sat_cnt) != SC * 3) fail_rpt("cnt_neg", int'(sat_cnt), SC * 3);

        @(posedge clk); #1;
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        @(negedge clk);
        tests++;
        if (sat_cnt !== 16'd0) fail_rpt("cnt_clr", int'(sat_cnt), 0);

        sent       = 0;
        acc        = 1'b0;
        stall_seen = 1'b0;
        stall_pix  = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (acc) sent++;
            out_ready = !(cyc >= 5 && cyc <= 9);
            in_valid  = (sent < 8);
            pix_in    = pk8(sent * 20 + 5, 0, 0, 0);
            coef_in   = pk10(256, 0, 0, 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid && out_ready) got.push_back(int'(out_pix));
            if (out_valid && !out_ready) begin
                tests++;
                if (in_ready !== 1'b0) fail_rpt("bp_rdy_low", int'(in_ready), 0);
                if (stall_seen) begin
                    tests++;
                    if (out_pix !== stall_pix) fail_rpt("bp_stable", int'(out_pix), int'(stall_pix));
                end
                stall_pix  = out_pix;
                stall_seen = 1'b1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tests++;
        if (stall_seen !== 1'b1) fail_rpt("bp_stalled", int'(stall_seen), 1);
        tests++;
        if (got.size() != 8) fail_rpt("bp_count", got.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < got.size()) begin
                tests++;
                if (got[i] != i * 20 + 5) fail_rpt("bp_order", got[i], i * 20 + 5);
            end
        end

        out_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            pix_in   = pk8(11 + b, 0, 0, 0);
            coef_in  = pk10(256, 0, 0, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 10) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        tests++;
        if (out_valid !== 1'b1) fail_rpt("mid_full", int'(out_valid), 1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0) fail_rpt("mid_rst_valid", int'(out_valid), 0);
        tests++;
        if (out_pix !== 8'd0) fail_rpt("mid_rst_pix", int'(out_pix), 0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) fail_rpt("mid_rel_rdy", int'(in_ready), 1);
        tests++;
        if (out_valid !== 1'b0) fail_rpt("mid_rel_valid", int'(out_valid), 0);
        run_one(pk8(0, 0, 42, 0), pk10(0, 0, 256, 0), 42, 0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
